biquad8_coeff_loader: RTL and testbench



---
 rtl/biquad8_coeff_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_biquad8_coeff_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_coeff_loader.sv
// rtl/biquad8_coeff_loader.sv - shadow-bank coefficient loader for the biquad8 head DSP
//
// Purpose:
//   The host fills a small shadow bank of filter coefficients through cfg_*.
//   A commit pulse then streams the bank into the filter, entry 0 first, one
//   coefficient per WRITE cycle with WR_GAP idle cycles after each write.
//   A final update strobe tells the filter to switch to the new set.
//
// Ports:
//   clk            sole clock, rising edge
//   aresetn        asynchronous active-low reset, release synchronized internally
//   cfg_addr_i     shadow-bank index for a host write
//   cfg_dat_i      host coefficient value
//   cfg_wr_i       host write strobe
//   commit_i       start a load sequence (single-cycle pulse)
//   busy_o         sequence in progress (first WRITE through UPDATE)
//   done_o         one-cycle pulse after the UPDATE cycle
//   wr_err_o       sticky: a host write or commit was rejected
//   coeff_dat_o    coefficient to the filter, 0 when coeff_wr_o is low
//   coeff_wr_o     filter coefficient load strobe
//   coeff_update_o filter coefficient update strobe
//   cfg_rd_dat_o   registered shadow readback (only with BIQUAD8_COEFF_READBACK_EN)
//
// Build option: define BIQUAD8_COEFF_READBACK_EN to add the readback port.

module biquad8_coeff_loader #(
   parameter int NCOEFF     = 2,
   parameter int COEFF_BITS = 18,
   parameter int WR_GAP     = 0,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic [ADDR_BITS-1:0]  cfg_addr_i,
   input  logic [COEFF_BITS-1:0] cfg_dat_i,
   input  logic                  cfg_wr_i,
   input  logic                  commit_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  wr_err_o,
   output logic [COEFF_BITS-1:0] coeff_dat_o,
   output logic                  coeff_wr_o,
   output logic                  coeff_update_o
`ifdef BIQUAD8_COEFF_READBACK_EN
   ,
   output logic [COEFF_BITS-1:0] cfg_rd_dat_o
`endif
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WRITE  = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;
   localparam logic [1:0] ST_UPDATE = 2'd3;

   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NCOEFF - 1);
   localparam logic [ADDR_BITS:0]   NCOEFF_W = (ADDR_BITS + 1)'(NCOEFF);
   // Unreachable value when WR_GAP is 0; the GAP state is never entered then.
   localparam logic [3:0]           GAP_LAST = 4'(WR_GAP - 1);

   // Reset synchronizer: assertion is immediate, release takes two edges.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n_int;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n_int  = rst_sync_q[1];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   logic [1:0]            state_q, state_d;
   logic [ADDR_BITS-1:0]  idx_q, idx_d;
   logic [3:0]            gap_q, gap_d;
   logic [COEFF_BITS-1:0] shadow_q [DEPTH];
   logic [COEFF_BITS-1:0] shadow_d [DEPTH];
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [COEFF_BITS-1:0] dat_q, dat_d;
   logic                  wr_q, wr_d;
   logic                  upd_q, upd_d;

   logic addr_ok;
   logic wr_ok;
   logic wr_rej;
   logic commit_ok;
   logic commit_rej;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      shadow_d = shadow_q;

      addr_ok    = ({1'b0, cfg_addr_i} < NCOEFF_W);
      wr_ok      = cfg_wr_i && !busy_q && addr_ok;
      wr_rej     = cfg_wr_i && (busy_q || !addr_ok);
      commit_ok  = commit_i && !busy_q;
      commit_rej = commit_i && busy_q;

      // Entries at or above NCOEFF are never written and stay constant zero.
      for (int i = 0; i < DEPTH; i++) begin
         if (i < NCOEFF && wr_ok && cfg_addr_i == ADDR_BITS'(i)) begin
            shadow_d[i] = cfg_dat_i;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (commit_ok) begin
               state_d = ST_WRITE;
               idx_d   = '0;
               gap_d   = '0;
            end
         end
         ST_WRITE: begin
            if (WR_GAP > 0) begin
               state_d = ST_GAP;
               gap_d   = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_UPDATE;
            end else begin
               idx_d = idx_q + ADDR_BITS'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_UPDATE;
               end else begin
                  state_d = ST_WRITE;
                  idx_d   = idx_q + ADDR_BITS'(1);
               end
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         ST_UPDATE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = '0;
         end
      endcase

      // Outputs are registered copies of the next state, so the first write
      // appears right after the commit edge. Reading shadow_d lets a write
      // coincident with the commit reach the filter.
      busy_d = (state_d != ST_IDLE);
      wr_d   = (state_d == ST_WRITE);
      dat_d  = wr_d ? shadow_d[idx_d] : '0;
      upd_d  = (state_d == ST_UPDATE);
      done_d = (state_q == ST_UPDATE);

      // A rejection in the same cycle wins over the clearing commit.
      if (wr_rej || commit_rej) begin
         err_d = 1'b1;
      end else if (commit_ok) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         gap_q    <= '0;
         shadow_q <= '{default: '0};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         wr_q     <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         shadow_q <= shadow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         wr_q     <= wr_d;
         upd_q    <= upd_d;
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign wr_err_o       = err_q;
   assign coeff_dat_o    = dat_q;
   assign coeff_wr_o     = wr_q;
   assign coeff_update_o = upd_q;

`ifdef BIQUAD8_COEFF_READBACK_EN
   logic [COEFF_BITS-1:0] rd_q, rd_d;

   assign rd_d = addr_ok ? shadow_q[cfg_addr_i] : '0;

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign cfg_rd_dat_o = rd_q;
`endif

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb/tb_biquad8_coeff_loader.sv - self-checking bench for biquad8_coeff_loader

module tb_biquad8_coeff_loader;

   localparam int NC = 2;
   localparam int CB = 18;
   localparam int AB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          aresetn;
   logic [AB-1:0] cfg_addr;
   logic [CB-1:0] cfg_dat;
   logic          cfg_wr;
   logic          commit;

   logic          c0_busy, c0_done, c0_err, c0_wr, c0_upd;
   logic [CB-1:0] c0_dat;
   logic          c1_busy, c1_done, c1_err, c1_wr, c1_upd;
   logic [CB-1:0] c1_dat;
`ifdef BIQUAD8_COEFF_READBACK_EN
   logic [CB-1:0] c0_rd, c1_rd;
`endif

   biquad8_coeff_loader #(.NCOEFF(NC), .COEFF_BITS(CB), .WR_GAP(0), .ADDR_BITS(AB)) dut0 (
      .clk(clk), .aresetn(aresetn), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat),
      .cfg_wr_i(cfg_wr), .commit_i(commit), .busy_o(c0_busy), .done_o(c0_done),
      .wr_err_o(c0_err), .coeff_dat_o(c0_dat), .coeff_wr_o(c0_wr), .coeff_update_o(c0_upd)
`ifdef BIQUAD8_COEFF_READBACK_EN
      , .cfg_rd_dat_o(c0_rd)
`endif
   );

   biquad8_coeff_loader #(.NCOEFF(NC), .COEFF_BITS(CB), .WR_GAP(2), .ADDR_BITS(AB)) dut1 (
      .clk(clk), .aresetn(aresetn), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat),
      .cfg_wr_i(cfg_wr), .commit_i(commit), .busy_o(c1_busy), .done_o(c1_done),
      .wr_err_o(c1_err), .coeff_dat_o(c1_dat), .coeff_wr_o(c1_wr), .coeff_update_o(c1_upd)
`ifdef BIQUAD8_COEFF_READBACK_EN
      , .cfg_rd_dat_o(c1_rd)
`endif
   );

   typedef struct packed {
      logic          wr;
      logic [CB-1:0] dat;
      logic          upd;
      logic          busy;
      logic          done;
      logic          err;
   } exp_t;

   // Reference model: per instance a shadow bank, a sticky error bit and a
   // queue holding the expected output of each future cycle of a sequence.
   exp_t          q0[$];
   exp_t          q1[$];
   exp_t          cur [2];
   logic [CB-1:0] shadow [2][NC];
   logic          err_n [2];
   logic [CB-1:0] rd_e [2];
   int            hold;
   bit            rel_pend;
   int            n_cmp;
   int            n_fail;

   logic [8:1] s0w, s0u, s0d, s0b, s1w, s1u, s1d, s1b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int g, input exp_t e);
      if (g == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic model_cycle(input int g, input int gap, input bit active);
      bit   busy, rej, acc;
      exp_t e;
      busy = cur[g].busy;
      rej  = 0;
      acc  = 0;
      rd_e[g] = '0;
      if (active) begin
         if (cfg_addr < NC) rd_e[g] = shadow[g][cfg_addr];
         if (cfg_wr) begin
            if (busy || cfg_addr >= NC) rej = 1;
            else shadow[g][cfg_addr] = cfg_dat;
         end
         if (commit) begin
            if (busy) rej = 1;
            else acc = 1;
         end
         if (rej) err_n[g] = 1'b1;
         else if (acc) err_n[g] = 1'b0;
         if (acc) begin
            for (int k = 0; k < NC; k++) begin
               e = '0; e.wr = 1'b1; e.dat = shadow[g][k]; e.busy = 1'b1; push(g, e);
               for (int j = 0; j < gap; j++) begin
                  e = '0; e.busy = 1'b1; push(g, e);
               end
            end
            e = '0; e.upd = 1'b1; e.busy = 1'b1; push(g, e);
            e = '0; e.done = 1'b1; push(g, e);
         end
      end
   endtask

   task automatic step();
      bit active;
      active = aresetn && (hold == 0);
      model_cycle(0, 0, active);
      model_cycle(1, 2, active);
      @(posedge clk);
      #1;
      if (aresetn && hold > 0) hold--;
      cur[0] = (q0.size() > 0) ? q0.pop_front() : '0;
      cur[1] = (q1.size() > 0) ? q1.pop_front() : '0;
      cur[0].err = err_n[0];
      cur[1].err = err_n[1];
      check("seq0", {c0_wr, c0_dat, c0_upd, c0_busy, c0_done, c0_err}, cur[0]);
      check("seq1", {c1_wr, c1_dat, c1_upd, c1_busy, c1_done, c1_err}, cur[1]);
`ifdef BIQUAD8_COEFF_READBACK_EN
      check("rd0", c0_rd, rd_e[0]);
      check("rd1", c1_rd, rd_e[1]);
`endif
   endtask

   task automatic drive(input logic w, input logic [AB-1:0] a, input logic [CB-1:0] d, input logic c);
      @(negedge clk);
      if (rel_pend) begin
         aresetn  = 1'b1;
         hold     = 2;
         rel_pend = 0;
      end
      cfg_wr   = w;
      cfg_addr = a;
      cfg_dat  = d;
      commit   = c;
      step();
   endtask

   task automatic do_reset(input int cyc);
      #2;
      aresetn = 1'b0;
      q0.delete();
      q1.delete();
      for (int g = 0; g < 2; g++) begin
         cur[g]   = '0;
         err_n[g] = 1'b0;
         for (int k = 0; k < NC; k++) shadow[g][k] = '0;
      end
      #1;
      check("rst_async0", {c0_wr, c0_dat, c0_upd, c0_busy, c0_done, c0_err}, 0);
      check("rst_async1", {c1_wr, c1_dat, c1_upd, c1_busy, c1_done, c1_err}, 0);
      repeat (cyc) drive(1'b0, '0, '0, 1'b0);
      rel_pend = 1;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      hold     = 0;
      rel_pend = 0;
      aresetn  = 1'b0;
      cfg_wr   = 1'b0;
      cfg_addr = '0;
      cfg_dat  = '0;
      commit   = 1'b0;
      for (int g = 0; g < 2; g++) begin
         cur[g]   = '0;
         err_n[g] = 1'b0;
         for (int k = 0; k < NC; k++) shadow[g][k] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      check("reset_state0", {c0_wr, c0_dat, c0_upd, c0_busy, c0_done, c0_err}, 0);
      check("reset_state1", {c1_wr, c1_dat, c1_upd, c1_busy, c1_done, c1_err}, 0);

      // Writes and commits during the two release-synchronizer edges are lost.
      rel_pend = 1;
      drive(1'b1, 4'd0, 18'h1FFFF, 1'b1);
      drive(1'b1, 4'd0, 18'h1FFFF, 1'b1);
      check("sync_hold", {c0_busy, c0_wr, c0_err, c1_busy}, 4'b0000);

      // Basic load: entry 0 then entry 1, update, done.
      drive(1'b1, 4'd0, 18'h00100, 1'b0);
      drive(1'b1, 4'd1, 18'h3FF00, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         drive(1'b0, 4'd0, '0, (c == 1));
         s0w[c] = c0_wr; s0u[c] = c0_upd; s0d[c] = c0_done; s0b[c] = c0_busy;
         s1w[c] = c1_wr; s1u[c] = c1_upd; s1d[c] = c1_done; s1b[c] = c1_busy;
         if (c == 1) check("d038_dat1", c0_dat, 18'h00100);
         if (c == 2) check("d038_dat2", c0_dat, 18'h3FF00);
         if (c == 4) check("d039_dat4", c1_dat, 18'h3FF00);
      end
      check("d038_wr",    s0w, 8'b0000_0011);
      check("d038_upd",   s0u, 8'b0000_0100);
      check("d038_done",  s0d, 8'b0000_1000);
      check("d038_busy",  s0b, 8'b0000_0111);
      check("d039_wr",    s1w, 8'b0000_1001);
      check("d039_upd",   s1u, 8'b0100_0000);
      check("d039_done",  s1d, 8'b1000_0000);
      check("d039_busy",  s1b, 8'b0111_1111);

      // Write and commit while busy are rejected; the sequence is unaffected.
      drive(1'b0, 4'd0, '0, 1'b1);
      drive(1'b1, 4'd0, 18'h12345, 1'b1);
      check("d040_err", {c0_err, c1_err}, 2'b11);
      check("d040_dat", {c0_wr, c0_dat}, {1'b1, 18'h3FF00});
      repeat (8) drive(1'b0, 4'd0, '0, 1'b0);
      check("d040_sticky", {c0_err, c1_err, c0_busy, c1_busy}, 4'b1100);
      drive(1'b0, 4'd0, '0, 1'b1);
      check("d040_clear", {c0_err, c1_err}, 2'b00);
      check("d040_shadow", {c0_wr, c0_dat}, {1'b1, 18'h00100});
      repeat (8) drive(1'b0, 4'd0, '0, 1'b0);

      // Out-of-range write.
      drive(1'b1, 4'd2, 18'h2AAAA, 1'b0);
      check("d042_err", c0_err, 1'b1);
      drive(1'b0, 4'd2, '0, 1'b0);
      drive(1'b0, 4'd1, '0, 1'b0);
`ifdef BIQUAD8_COEFF_READBACK_EN
      check("d042_rd_valid", c0_rd, 18'h3FF00);
`endif

      // Write coincident with an accepted commit lands first.
      drive(1'b1, 4'd0, 18'h0ABCD, 1'b1);
      check("d023_dat", {c0_wr, c0_dat}, {1'b1, 18'h0ABCD});
      check("d022_clear", c0_err, 1'b0);
      repeat (8) drive(1'b0, 4'd0, '0, 1'b0);

      // Accepted commit with a coincident rejected write keeps the error.
      drive(1'b1, 4'd5, 18'h00777, 1'b1);
      check("d022_keep", {c0_err, c0_busy, c0_wr}, 3'b111);
      repeat (8) drive(1'b0, 4'd0, '0, 1'b0);

      // Reset in the second cycle of a sequence aborts it.
      drive(1'b0, 4'd0, '0, 1'b1);
      drive(1'b0, 4'd0, '0, 1'b0);
      do_reset(2);
      repeat (6) drive(1'b0, 4'd0, '0, 1'b0);
      check("d041_abort", {c0_upd, c0_done, c1_upd, c1_done, c1_wr}, 5'b00000);

      // Randomized traffic against the model, with one random reset.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset($urandom_range(1, 3));
         drive(($urandom_range(0, 3) == 0),
               (($urandom_range(0, 9) == 0) ? 4'd15 : AB'($urandom_range(0, 3))),
               CB'($urandom),
               ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
